lsb_queue: RTL

// - In-order load/store buffer. Accepts memory ops from the decoder issue path, waits for operand wakeup,

---
 rtl/lsb_queue.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsb_queue.sv
`default_nettype none
// lsb_queue: in-order load/store buffer, single outstanding memory request, result broadcast.
// Optional macro LSB_ISSUE_WAKEUP_EN: an issuing entry captures a same-cycle matching broadcast.
module lsb_queue #(
  parameter int LSB_SIZE = 8,
  parameter int LSB_BIT  = 3,
  parameter int ROB_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear_up,
  input  logic             issue_signal,
  input  logic [6:0]       op_type_in,
  input  logic [2:0]       op_in,
  input  logic [31:0]      reg1_v_in,
  input  logic [31:0]      reg2_v_in,
  input  logic             has_dep1_in,
  input  logic             has_dep2_in,
  input  logic [ROB_W-1:0] rob_entry1_in,
  input  logic [ROB_W-1:0] rob_entry2_in,
  input  logic [ROB_W-1:0] rd_rob_in,
  input  logic [31:0]      imm_in,
  input  logic             rs_ready,
  input  logic [ROB_W-1:0] rs_rob_entry,
  input  logic [31:0]      rs_value,
  input  logic             rob_commit_valid,
  input  logic [ROB_W-1:0] rob_commit_entry,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_len,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             lsb_ready,
  output logic [ROB_W-1:0] lsb_rob_entry,
  output logic [31:0]      lsb_value,
  output logic             is_full
);
  localparam logic [6:0]       C_OP_STORE = 7'b0100011;
  localparam logic [LSB_BIT:0] C_FULL     = (LSB_BIT+1)'(LSB_SIZE);
  localparam logic [LSB_BIT:0] C_ONE_CNT  = (LSB_BIT+1)'(1);
  localparam logic [LSB_BIT-1:0] C_ONE_PTR = LSB_BIT'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DRAIN = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  logic [LSB_SIZE-1:0] r_valid, r_dep1, r_dep2, r_committed, r_announced, r_is_store;
  logic [2:0]       r_op   [LSB_SIZE];
  logic [31:0]      r_v1   [LSB_SIZE];
  logic [31:0]      r_v2   [LSB_SIZE];
  logic [31:0]      r_imm  [LSB_SIZE];
  logic [ROB_W-1:0] r_tag1 [LSB_SIZE];
  logic [ROB_W-1:0] r_tag2 [LSB_SIZE];
  logic [ROB_W-1:0] r_rd   [LSB_SIZE];
  logic [LSB_BIT-1:0] r_head, r_tail;
  logic [LSB_BIT:0]   r_count;

  logic w_head_store, w_head_ready, w_start_load, w_start_store, w_announce;
  logic w_done, w_pop, w_enq, w_load_result, w_run;
  logic [LSB_SIZE-1:0] w_commit_hit, w_keep, w_wk1_rs, w_wk1_lsb, w_wk2_rs, w_wk2_lsb;
  logic [LSB_BIT:0]   w_keep_cnt;
  logic [LSB_BIT-1:0] w_idx;
  logic [31:0] w_ld_value, w_in_v1, w_in_v2;
  logic w_in_dep1, w_in_dep2;

  assign is_full = (r_count == C_FULL);
  assign w_enq   = issue_signal && !rob_clear_up && !is_full;

  always_comb begin
    w_head_store  = r_is_store[r_head];
    w_head_ready  = r_valid[r_head] && !r_dep1[r_head] && !r_dep2[r_head];
    w_start_load  = 1'b0;
    w_start_store = 1'b0;
    w_announce    = 1'b0;
    w_done        = 1'b0;
    w_pop         = 1'b0;
    w_state_nxt   = r_state;
    case (r_state)
      S_IDLE: begin
        if (!rob_clear_up && w_head_ready) begin
          if (!w_head_store) begin
            w_start_load = 1'b1;
            w_state_nxt  = S_BUSY;
          end else if (r_committed[r_head]) begin
            w_start_store = 1'b1;
            w_state_nxt   = S_BUSY;
          end else if (!r_announced[r_head]) begin
            w_announce = 1'b1;
          end
        end
      end
      S_BUSY: begin
        // A flushed load is already gone from the queue, so it is never popped.
        if (mem_done) begin
          w_done      = 1'b1;
          w_pop       = !(rob_clear_up && !w_head_store);
          w_state_nxt = S_IDLE;
        end else if (rob_clear_up && !w_head_store) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_load_result = w_done && (r_state == S_BUSY) && !w_head_store && !rob_clear_up;
  end

  always_comb begin
    w_keep     = '0;
    w_keep_cnt = '0;
    w_run      = 1'b1;
    w_idx      = r_head;
    for (int i = 0; i < LSB_SIZE; i++) begin
      w_commit_hit[i] = r_valid[i] && r_is_store[i] && rob_commit_valid && (r_rd[i] == rob_commit_entry);
      w_wk1_rs[i]  = r_valid[i] && r_dep1[i] && rs_ready  && (r_tag1[i] == rs_rob_entry);
      w_wk1_lsb[i] = r_valid[i] && r_dep1[i] && lsb_ready && (r_tag1[i] == lsb_rob_entry);
      w_wk2_rs[i]  = r_valid[i] && r_dep2[i] && rs_ready  && (r_tag2[i] == rs_rob_entry);
      w_wk2_lsb[i] = r_valid[i] && r_dep2[i] && lsb_ready && (r_tag2[i] == lsb_rob_entry);
    end
    // Flush keeps only the committed run that starts at the head.
    for (int j = 0; j < LSB_SIZE; j++) begin
      w_idx = r_head + LSB_BIT'(j);
      if (w_run && r_valid[w_idx] && (r_committed[w_idx] || w_commit_hit[w_idx])) begin
        w_keep[w_idx] = 1'b1;
        w_keep_cnt    = w_keep_cnt + C_ONE_CNT;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_comb begin
    w_in_v1   = reg1_v_in;
    w_in_v2   = reg2_v_in;
    w_in_dep1 = has_dep1_in;
    w_in_dep2 = has_dep2_in;
`ifdef LSB_ISSUE_WAKEUP_EN
    if (has_dep1_in && rs_ready && (rs_rob_entry == rob_entry1_in)) begin
      w_in_v1 = rs_value;   w_in_dep1 = 1'b0;
    end else if (has_dep1_in && lsb_ready && (lsb_rob_entry == rob_entry1_in)) begin
      w_in_v1 = lsb_value;  w_in_dep1 = 1'b0;
    end
    if (has_dep2_in && rs_ready && (rs_rob_entry == rob_entry2_in)) begin
      w_in_v2 = rs_value;   w_in_dep2 = 1'b0;
    end else if (has_dep2_in && lsb_ready && (lsb_rob_entry == rob_entry2_in)) begin
      w_in_v2 = lsb_value;  w_in_dep2 = 1'b0;
    end
`else
`endif
  end

  always_comb begin
    case (r_op[r_head])
      3'd0:    w_ld_value = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    w_ld_value = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    w_ld_value = {24'b0, mem_rdata[7:0]};
      3'd5:    w_ld_value = {16'b0, mem_rdata[15:0]};
      default: w_ld_value = mem_rdata;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (w_wk1_rs[i])       r_v1[i] <= rs_value;
        else if (w_wk1_lsb[i]) r_v1[i] <= lsb_value;
        if (w_wk2_rs[i])       r_v2[i] <= rs_value;
        else if (w_wk2_lsb[i]) r_v2[i] <= lsb_value;
      end
      if (w_enq) begin
        r_v1[r_tail]       <= w_in_v1;
        r_v2[r_tail]       <= w_in_v2;
        r_imm[r_tail]      <= imm_in;
        r_op[r_tail]       <= op_in;
        r_tag1[r_tail]     <= rob_entry1_in;
        r_tag2[r_tail]     <= rob_entry2_in;
        r_rd[r_tail]       <= rd_rob_in;
        r_is_store[r_tail] <= (op_type_in == C_OP_STORE);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_valid       <= '0;
      r_dep1        <= '0;
      r_dep2        <= '0;
      r_committed   <= '0;
      r_announced   <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_len       <= '0;
      lsb_ready     <= 1'b0;
      lsb_rob_entry <= '0;
      lsb_value     <= '0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      lsb_ready   <= 1'b0;
      r_dep1      <= r_dep1 & ~(w_wk1_rs | w_wk1_lsb);
      r_dep2      <= r_dep2 & ~(w_wk2_rs | w_wk2_lsb);
      r_committed <= r_committed | w_commit_hit;
      if (w_start_load || w_start_store) begin
        mem_req   <= 1'b1;
        mem_we    <= w_start_store;
        mem_addr  <= r_v1[r_head] + r_imm[r_head];
        mem_wdata <= r_v2[r_head];
        mem_len   <= r_op[r_head][1:0];
      end
      if (w_done) mem_req <= 1'b0;
      if (w_load_result) begin
        lsb_ready     <= 1'b1;
        lsb_rob_entry <= r_rd[r_head];
        lsb_value     <= w_ld_value;
      end else if (w_announce) begin
        lsb_ready              <= 1'b1;
        lsb_rob_entry          <= r_rd[r_head];
        lsb_value              <= '0;
        r_announced[r_head]    <= 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + C_ONE_PTR;
      end
      if (w_enq) begin
        r_valid[r_tail]     <= 1'b1;
        r_dep1[r_tail]      <= w_in_dep1;
        r_dep2[r_tail]      <= w_in_dep2;
        r_committed[r_tail] <= 1'b0;
        r_announced[r_tail] <= 1'b0;
        r_tail              <= r_tail + C_ONE_PTR;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + C_ONE_CNT;
        2'b01:   r_count <= r_count - C_ONE_CNT;
        default: r_count <= r_count;
      endcase
      if (rob_clear_up) begin
        r_valid <= w_keep & ~(w_pop ? (LSB_SIZE'(1) << r_head) : '0);
        r_tail  <= r_head + w_keep_cnt[LSB_BIT-1:0];
        r_count <= w_keep_cnt - (w_pop ? C_ONE_CNT : '0);
      end
    end
  end
endmodule
`default_nettype wire
